data_mem_responder: RTL and testbench

Memory-side responder for the core's load/store port. It accepts one request at a time, encoded with the core's `mem_inst_type_t` (LB/LH/LW/LBU/LHU/SB/SH/SW/NOP), and performs the byte-, half- or word-sized access on an internal word-organised RAM. After a configurable number of wait states it returns sign- or zero-extended load data, or an error flag for misaligned or out-of-range accesses. It sits between the core's MEM stage and the data RAM and is the counterpart of the core's memory-request encoding.

---
 rtl/data_mem_responder.sv | 180 ++++++++++++++++++
 tb/tb_data_mem_responder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - load/store memory responder with wait states and error flagging
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);
  localparam logic [3:0]  WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        state_q, state_d;
  logic [3:0]    type_q, type_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          err_q, err_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:0]   rdata_q;
  logic          rsp_err_q;
  logic          go_resp;

  logic [31:0]   ram_q [DEPTH_WORDS];

  logic          legal, is_nop, misal, oor, err_in;
  logic [3:0]    cur_type;
  logic [AW+1:0] cur_addr;
  logic [31:0]   cur_wdata;
  logic          cur_err;
  logic [31:0]   word, load_v, wlane;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic [3:0]    be;

  // Classify the incoming request: illegal encoding, misalignment, out of range.
  always_comb begin
    legal = 1'b0;
    case (req_type)
      4'b1110, 4'b1010, 4'b1100, 4'b1111, 4'b1011,
      4'b0110, 4'b0010, 4'b0100, 4'b0000: legal = 1'b1;
      default:                            legal = 1'b0;
    endcase
    is_nop = (req_type == 4'b0000);
    misal  = ((req_type[2:1] == 2'b01) && req_addr[0]) ||
             ((req_type[2:1] == 2'b10) && (req_addr[1:0] != 2'b00));
    oor    = ({2'b00, req_addr[31:2]} >= DEPTH_L);
    err_in = !legal || (!is_nop && (misal || oor));
  end

  // FSM next state and request latching; go_resp marks the edge entering RESP.
  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    go_resp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          type_d  = req_type;
          addr_d  = req_addr[AW+1:0];
          wdata_d = req_wdata;
          err_d   = err_in;
          cnt_d   = WS_INIT;
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_RESP;
            go_resp = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          go_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Access datapath: with zero wait states the live request is used directly.
  always_comb begin
    cur_type  = (state_q == S_IDLE) ? req_type          : type_q;
    cur_addr  = (state_q == S_IDLE) ? req_addr[AW+1:0]  : addr_q;
    cur_wdata = (state_q == S_IDLE) ? req_wdata         : wdata_q;
    cur_err   = (state_q == S_IDLE) ? err_in            : err_q;
    word      = ram_q[cur_addr[AW+1:2]];
    byte_v    = word[{cur_addr[1:0], 3'b000} +: 8];
    half_v    = word[{cur_addr[1], 4'b0000} +: 16];
    load_v    = 32'd0;
    be        = 4'b0000;
    wlane     = 32'd0;
    if (!cur_err && cur_type[3]) begin
      case (cur_type[2:1])
        2'b11:   load_v = cur_type[0] ? {24'd0, byte_v} : {{24{byte_v[7]}}, byte_v};
        2'b01:   load_v = cur_type[0] ? {16'd0, half_v} : {{16{half_v[15]}}, half_v};
        2'b10:   load_v = word;
        default: load_v = 32'd0;
      endcase
    end
    if (!cur_err && !cur_type[3]) begin
      case (cur_type[2:1])
        2'b11: begin
          be    = 4'b0001 << cur_addr[1:0];
          wlane = {4{cur_wdata[7:0]}};
        end
        2'b01: begin
          be    = cur_addr[1] ? 4'b1100 : 4'b0011;
          wlane = {2{cur_wdata[15:0]}};
        end
        2'b10: begin
          be    = 4'b1111;
          wlane = cur_wdata;
        end
        default: be = 4'b0000;
      endcase
    end
  end

  // State and response registers; the response is captured on entry to RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      type_q    <= 4'd0;
      addr_q    <= '0;
      wdata_q   <= 32'd0;
      err_q     <= 1'b0;
      cnt_q     <= 4'd0;
      rdata_q   <= 32'd0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      if (go_resp) begin
        rdata_q   <= load_v;
        rsp_err_q <= cur_err;
      end
    end
  end

  // Byte-lane RAM write on entry to RESP; a reset on that edge drops the store.
  always_ff @(posedge clk) begin
    if (go_resp && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) ram_q[cur_addr[AW+1:2]][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_error = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking bench for data_mem_responder
module tb_data_mem_responder;

  localparam int DEPTH = 1024;
  localparam int WS0   = 1;
  localparam int WS1   = 3;

  localparam logic [3:0] LB  = 4'b1110, LH  = 4'b1010, LW = 4'b1100;
  localparam logic [3:0] LBU = 4'b1111, LHU = 4'b1011;
  localparam logic [3:0] SB  = 4'b0110, SH  = 4'b0010, SW = 4'b0100, NOP = 4'b0000;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst, req_valid, req_ready, rsp_valid, rsp_ready, rsp_error;
  logic [3:0]  req_type  [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [31:0] rsp_rdata [2];

  int errors = 0;
  int checks = 0;

  logic [31:0] model_mem [int];

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS0)) dut0 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_type(req_type[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_error(rsp_error[0])
  );

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS1)) dut1 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_type(req_type[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_error(rsp_error[1])
  );

  // Reference model: byte-addressed view of memory with plain arithmetic.
  task automatic model_access(input logic [3:0] t, input logic [31:0] a, input logic [31:0] wd,
                              output logic [31:0] rd, output logic er);
    int          size, k;
    logic [31:0] w, val, nw, mask;
    rd   = 32'd0;
    size = (t[2:1] == 2'b11) ? 1 : (t[2:1] == 2'b01) ? 2 : 4;
    er   = !(t inside {LB, LH, LW, LBU, LHU, SB, SH, SW, NOP}) ||
           (t != NOP && (((a % size) != 0) || ((a / 4) >= DEPTH)));
    if (er || t == NOP) return;
    w = model_mem.exists(int'(a / 4)) ? model_mem[int'(a / 4)] : 32'd0;
    if (t[3]) begin
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
      val  = (w >> (8 * (a % 4))) & mask;
      if (!t[0] && size < 4 && val >= (32'd1 << (8 * size - 1))) val = val - (32'd1 << (8 * size));
      rd = val;
    end else begin
      nw = w;
      for (int i = 0; i < size; i++) begin
        k  = int'(a % 4) + i;
        nw = (nw & ~(32'hFF << (8 * k))) | (((wd >> (8 * i)) & 32'hFF) << (8 * k));
      end
      model_mem[int'(a / 4)] = nw;
    end
  endtask

  task automatic start_req(input int d, input logic [3:0] t, input logic [31:0] a, input logic [31:0] wd);
    int n = 0;
    @(negedge clk);
    req_valid[d] = 1'b1; req_type[d] = t; req_addr[d] = a; req_wdata[d] = wd;
    while (!req_ready[d] && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (!req_ready[d]) begin errors++; $display("FAIL accept_timeout dut%0d: req_ready=%b required 1", d, req_ready[d]); end
    @(posedge clk);
    #1 req_valid[d] = 1'b0;
  endtask

  task automatic wait_rsp(input int d, input int hold, output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    lat = 1;
    while (!rsp_valid[d] && lat < 60) begin @(negedge clk); lat++; end
    checks++;
    if (!rsp_valid[d]) begin errors++; $display("FAIL rsp_timeout dut%0d: rsp_valid=%b required 1", d, rsp_valid[d]); end
    repeat (hold) @(negedge clk);
    rd = rsp_rdata[d]; er = rsp_error[d];
    rsp_ready[d] = 1'b1;
    @(posedge clk);
    #1 rsp_ready[d] = 1'b0;
  endtask

  task automatic do_access(input int d, input logic [3:0] t, input logic [31:0] a, input logic [31:0] wd,
                           input int hold, output logic [31:0] rd, output logic er, output int lat);
    start_req(d, t, a, wd);
    wait_rsp(d, hold, rd, er, lat);
  endtask

  task automatic test_reset();
    rst = 2'b11; req_valid = 2'b00; rsp_ready = 2'b00;
    for (int d = 0; d < 2; d++) begin req_type[d] = 4'd0; req_addr[d] = 32'd0; req_wdata[d] = 32'd0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b required 1", req_ready[0]); end
    checks++; if (rsp_valid[0] !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b required 0", rsp_valid[0]); end
    checks++; if (rsp_rdata[0] !== 32'd0) begin errors++; $display("FAIL reset_rsp_rdata: got %h required 0", rsp_rdata[0]); end
    checks++; if (rsp_error[0] !== 1'b0) begin errors++; $display("FAIL reset_rsp_error: got %b required 0", rsp_error[0]); end
    rst = 2'b00;
  endtask

  task automatic test_word_store_load();
    logic [31:0] rd; logic er; int lat;
    do_access(0, SW, 32'h10, 32'hDEAD_BEEF, 0, rd, er, lat);
    checks++; if (er !== 1'b0 || rd !== 32'd0) begin errors++; $display("FAIL sw_rsp: got err=%b rdata=%h required err=0 rdata=0", er, rd); end
    checks++; if (lat != 1 + WS0) begin errors++; $display("FAIL sw_latency: got %0d required %0d", lat, 1 + WS0); end
    do_access(0, LW, 32'h10, 32'h0, 0, rd, er, lat);
    checks++; if (er !== 1'b0 || rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_rsp: got err=%b rdata=%h required err=0 rdata=deadbeef", er, rd); end
    checks++; if (lat != 1 + WS0) begin errors++; $display("FAIL lw_latency: got %0d required %0d", lat, 1 + WS0); end
  endtask

  task automatic test_subword_loads();
    logic [3:0]  ty  [5] = '{LB, LBU, LH, LHU, LH};
    logic [31:0] ad  [5] = '{32'h23, 32'h23, 32'h20, 32'h22, 32'h22};
    logic [31:0] exp [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_7F01, 32'h0000_80FF, 32'hFFFF_80FF};
    logic [31:0] rd; logic er; int lat;
    do_access(0, SW, 32'h20, 32'h80FF_7F01, 0, rd, er, lat);
    for (int i = 0; i < 5; i++) begin
      do_access(0, ty[i], ad[i], 32'h0, 0, rd, er, lat);
      checks++;
      if (er !== 1'b0 || rd !== exp[i]) begin
        errors++; $display("FAIL subword_%0d: got err=%b rdata=%h required err=0 rdata=%h", i, er, rd, exp[i]);
      end
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd; logic er; int lat;
    do_access(0, SW, 32'h30, 32'h0, 0, rd, er, lat);
    do_access(0, SB, 32'h31, 32'h0000_00AB, 0, rd, er, lat);
    do_access(0, SH, 32'h32, 32'h0000_1234, 0, rd, er, lat);
    do_access(0, LW, 32'h30, 32'h0, 0, rd, er, lat);
    checks++; if (rd !== 32'h1234_AB00) begin errors++; $display("FAIL byte_lanes: got %h required 1234ab00", rd); end
  endtask

  task automatic test_errors();
    logic [3:0]  ty [6] = '{LW, SH, SW, LW, 4'b1000, NOP};
    logic [31:0] ad [6] = '{32'h02, 32'h05, 32'(4 * DEPTH), 32'(4 * DEPTH + 8), 32'h10, 32'h03};
    logic        ee [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] rd; logic er; int lat;
    do_access(0, SW, 32'h00, 32'hCAFE_F00D, 0, rd, er, lat);
    do_access(0, SW, 32'h04, 32'h0123_4567, 0, rd, er, lat);
    do_access(0, SW, 32'(4 * DEPTH - 4), 32'h5A5A_A5A5, 0, rd, er, lat);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL last_word_store: got err=%b required 0", er); end
    for (int i = 0; i < 6; i++) begin
      do_access(0, ty[i], ad[i], 32'hFFFF_FFFF, 0, rd, er, lat);
      checks++;
      if (er !== ee[i] || rd !== 32'd0) begin
        errors++; $display("FAIL error_case_%0d: got err=%b rdata=%h required err=%b rdata=0", i, er, rd, ee[i]);
      end
    end
    do_access(0, LW, 32'h00, 32'h0, 0, rd, er, lat);
    checks++; if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL err_reread_0: got %h required cafef00d", rd); end
    do_access(0, LW, 32'h04, 32'h0, 0, rd, er, lat);
    checks++; if (rd !== 32'h0123_4567) begin errors++; $display("FAIL err_reread_4: got %h required 01234567", rd); end
    do_access(0, LW, 32'h10, 32'h0, 0, rd, er, lat);
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL err_reread_10: got %h required deadbeef", rd); end
    do_access(0, LW, 32'(4 * DEPTH - 4), 32'h0, 0, rd, er, lat);
    checks++; if (er !== 1'b0 || rd !== 32'h5A5A_A5A5) begin errors++; $display("FAIL last_word_load: got err=%b rdata=%h required 0 5a5aa5a5", er, rd); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; int lat; int n = 0; int extra = 0;
    start_req(0, LW, 32'h10, 32'h0);
    @(negedge clk);
    while (!rsp_valid[0] && n < 50) begin @(negedge clk); n++; end
    req_valid[0] = 1'b1; req_type[0] = SW; req_addr[0] = 32'h10; req_wdata[0] = 32'h0BAD_BAD0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 32'hDEAD_BEEF || rsp_error[0] !== 1'b0 || req_ready[0] !== 1'b0) begin
        errors++; $display("FAIL backpressure_hold_%0d: got valid=%b rdata=%h err=%b req_ready=%b required 1 deadbeef 0 0",
                            i, rsp_valid[0], rsp_rdata[0], rsp_error[0], req_ready[0]);
      end
    end
    req_valid[0] = 1'b0; rsp_ready[0] = 1'b1;
    @(posedge clk);
    #1 rsp_ready[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin @(negedge clk); if (rsp_valid[0]) extra++; end
    checks++; if (extra != 0 || req_ready[0] !== 1'b1) begin errors++; $display("FAIL backpressure_release: got extra_valid=%0d req_ready=%b required 0 1", extra, req_ready[0]); end
    do_access(0, LW, 32'h10, 32'h0, 0, rd, er, lat);
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL backpressure_ignored_req: got %h required deadbeef", rd); end
  endtask

  task automatic test_random();
    logic [3:0]  legal [9] = '{LB, LH, LW, LBU, LHU, SB, SH, SW, NOP};
    logic [3:0]  t;
    logic [31:0] a, wd, rd, erd; logic er, eer; int lat;
    for (int w = 0; w < 16; w++) begin
      wd = $urandom;
      model_access(SW, 32'(4 * w), wd, erd, eer);
      do_access(0, SW, 32'(4 * w), wd, 0, rd, er, lat);
    end
    for (int i = 0; i < 80; i++) begin
      t  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : legal[$urandom_range(0, 8)];
      a  = ($urandom_range(0, 9) == 0) ? 32'(4 * (DEPTH + $urandom_range(0, 100)) + $urandom_range(0, 3))
                                       : 32'(4 * $urandom_range(0, 15) + $urandom_range(0, 3));
      wd = $urandom;
      model_access(t, a, wd, erd, eer);
      do_access(0, t, a, wd, $urandom_range(0, 2), rd, er, lat);
      checks++;
      if (rd !== erd || er !== eer || lat != 1 + WS0) begin
        errors++; $display("FAIL random_%0d type=%b addr=%h: got rdata=%h err=%b lat=%0d required rdata=%h err=%b lat=%0d",
                            i, t, a, rd, er, lat, erd, eer, 1 + WS0);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat; int n = 0;
    do_access(1, SW, 32'h40, 32'h11, 0, rd, er, lat);
    do_access(1, LW, 32'h40, 32'h0, 0, rd, er, lat);
    checks++; if (rd !== 32'h11 || lat != 1 + WS1) begin errors++; $display("FAIL ws3_load: got rdata=%h lat=%0d required 11 %0d", rd, lat, 1 + WS1); end
    start_req(1, SW, 32'h40, 32'h55);
    @(negedge clk);
    rst[1] = 1'b1;
    @(posedge clk);
    #1 rst[1] = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready[1] !== 1'b1 || rsp_valid[1] !== 1'b0 || rsp_rdata[1] !== 32'd0 || rsp_error[1] !== 1'b0) begin
      errors++; $display("FAIL reset_mid_outputs: got ready=%b valid=%b rdata=%h err=%b required 1 0 0 0",
                          req_ready[1], rsp_valid[1], rsp_rdata[1], rsp_error[1]);
    end
    do_access(1, LW, 32'h40, 32'h0, 0, rd, er, lat);
    checks++; if (rd !== 32'h11) begin errors++; $display("FAIL reset_mid_uncommitted: got %h required 00000011", rd); end
    do_access(1, SW, 32'h44, 32'h66, 0, rd, er, lat);
    start_req(1, SW, 32'h44, 32'h77);
    @(negedge clk);
    while (!rsp_valid[1] && n < 50) begin @(negedge clk); n++; end
    rst[1] = 1'b1;
    @(posedge clk);
    #1 rst[1] = 1'b0;
    @(negedge clk);
    checks++; if (rsp_valid[1] !== 1'b0) begin errors++; $display("FAIL reset_in_resp_valid: got %b required 0", rsp_valid[1]); end
    do_access(1, LW, 32'h44, 32'h0, 0, rd, er, lat);
    checks++; if (rd !== 32'h77) begin errors++; $display("FAIL reset_mid_committed: got %h required 00000077", rd); end
  endtask

  initial begin
    test_reset();
    test_word_store_load();
    test_subword_loads();
    test_byte_lanes();
    test_errors();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
